// File: rtl/contador_pkg.sv
// Shared constants for the counter family: FSM state encoding and default sizing.
package contador_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int DEFAULT_MODULO = 16;

endpackage

// File: rtl/flipflop_t_sync.sv
// Single T flip-flop with synchronous active-high clear and parallel load.
module flipflop_t_sync (
    input  logic clk,
    input  logic clear,
    input  logic t,
    input  logic load,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (clear)
            q <= 1'b0;
        else if (load)
            q <= d;
        else if (t)
            q <= ~q;
    end

endmodule

// File: rtl/contador_sincrono_decrescente_4bits.sv
// Synchronous down counter with parallel load, programmable modulus,
// cascade borrow and a one-shot countdown mode.
module contador_sincrono_decrescente_4bits
    import contador_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int MODULO = DEFAULT_MODULO
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             T,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             single,
    output logic [WIDTH-1:0] q,
    output logic             borrow,
    output logic             done
);

    localparam logic [WIDTH-1:0] WRAP_VALUE = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MODULO_EXT = (WIDTH + 1)'(MODULO);

    logic [1:0]       state;
    logic             at_zero;
    logic             active;
    logic             dec_en;
    logic             wrap_en;
    logic             stop_en;
    logic [WIDTH-1:0] load_value;
    logic             ff_load;
    logic [WIDTH-1:0] ff_d;

    // IDLE counts exactly like RUN; only DONE freezes the count.
    assign at_zero    = (q == '0);
    assign active     = T && (state != ST_DONE);
    assign dec_en     = active && !at_zero;
    assign wrap_en    = active && at_zero && !single;
    assign stop_en    = active && at_zero && single;
    assign load_value = ({1'b0, d} < MODULO_EXT) ? d : WRAP_VALUE;

    // Wraps reuse the flops' load path so any modulus lands on MODULO-1 in one edge.
    assign ff_load = load || wrap_en;
    assign ff_d    = load ? load_value : WRAP_VALUE;

    assign borrow = T && !clear && !load && at_zero && (state != ST_DONE) && !single;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((1 << i) - 1);
        logic toggle;

        // A bit flips on decrement when every lower bit is zero.
        assign toggle = dec_en && ((q & LOW_MASK) == '0);

        flipflop_t_sync u_ff (
            .clk   (clk),
            .clear (clear),
            .t     (toggle),
            .load  (ff_load),
            .d     (ff_d[i]),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else if (load) begin
            state <= ST_RUN;
            done  <= 1'b0;
        end else if (stop_en) begin
            state <= ST_DONE;
            done  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_contador_sincrono_decrescente_4bits.sv
// Bench for the down counter: a MODULO=16 and a MODULO=10 instance share stimulus
// and are compared each cycle against an arithmetic reference model.
module tb_contador_sincrono_decrescente_4bits;

    logic       clk;
    logic       clear;
    logic       T;
    logic       load;
    logic [3:0] d;
    logic       single;

    logic [3:0] q_o      [2];
    logic       borrow_o [2];
    logic       done_o   [2];

    int mq       [2];
    bit mfin     [2];
    int mmod     [2];
    int bcnt     [2];
    bit last_b   [2];

    int n_checks = 0;
    int n_fail   = 0;

    contador_sincrono_decrescente_4bits #(.WIDTH(4), .MODULO(16)) u_m16 (
        .clk    (clk),
        .clear  (clear),
        .T      (T),
        .load   (load),
        .d      (d),
        .single (single),
        .q      (q_o[0]),
        .borrow (borrow_o[0]),
        .done   (done_o[0])
    );

    contador_sincrono_decrescente_4bits #(.WIDTH(4), .MODULO(10)) u_m10 (
        .clk    (clk),
        .clear  (clear),
        .T      (T),
        .load   (load),
        .d      (d),
        .single (single),
        .q      (q_o[1]),
        .borrow (borrow_o[1]),
        .done   (done_o[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: one clock edge of the counter as plain arithmetic.
    task automatic model_edge(input int k, input bit c, input bit t, input bit l,
                              input int dv, input bit s);
        if (c) begin
            mq[k]   = 0;
            mfin[k] = 1'b0;
        end else if (l) begin
            mq[k]   = (dv < mmod[k]) ? dv : mmod[k] - 1;
            mfin[k] = 1'b0;
        end else if (!mfin[k] && t) begin
            if (mq[k] != 0)
                mq[k] = mq[k] - 1;
            else if (s)
                mfin[k] = 1'b1;
            else
                mq[k] = mmod[k] - 1;
        end
    endtask

    // Drive one cycle of inputs after a falling edge, check borrow before the
    // rising edge and q/done just after it.
    task automatic step(input bit c, input bit t, input bit l, input logic [3:0] dv, input bit s);
        bit exp_b;
        clear  = c;
        T      = t;
        load   = l;
        d      = dv;
        single = s;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_b = t && !c && !l && (mq[k] == 0) && !mfin[k] && !s;
            chk($sformatf("borrow[%0d]", k), 4'(borrow_o[k]), 4'(exp_b));
            last_b[k] = borrow_o[k];
            if (borrow_o[k] === 1'b1)
                bcnt[k]++;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++)
            model_edge(k, c, t, l, int'(dv), s);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("q[%0d]", k), q_o[k], 4'(mq[k]));
            chk($sformatf("done[%0d]", k), 4'(done_o[k]), 4'(mfin[k]));
        end
        @(negedge clk);
    endtask

    initial begin
        clk    = 1'b0;
        clear  = 1'b0;
        T      = 1'b0;
        load   = 1'b0;
        d      = 4'd0;
        single = 1'b0;
        mmod[0] = 16;
        mmod[1] = 10;
        for (int k = 0; k < 2; k++) begin
            mq[k]     = 0;
            mfin[k]   = 1'b0;
            bcnt[k]   = 0;
            last_b[k] = 1'b0;
        end
        @(negedge clk);

        // Reset wins over load and count.
        step(1, 1, 1, 4'd9, 0);
        step(1, 1, 1, 4'd9, 0);
        chk("reset_q", q_o[0], 4'd0);
        chk("reset_done", 4'(done_o[0]), 4'd0);

        // Continuous wrap 2,1,0,15,14 with a single borrow.
        bcnt[0] = 0;
        step(0, 0, 1, 4'd2, 0);
        chk("wrap_load", q_o[0], 4'd2);
        step(0, 1, 0, 4'd0, 0);
        chk("wrap_1", q_o[0], 4'd1);
        step(0, 1, 0, 4'd0, 0);
        chk("wrap_0", q_o[0], 4'd0);
        step(0, 1, 0, 4'd0, 0);
        chk("wrap_borrow_at0", 4'(last_b[0]), 4'd1);
        chk("wrap_15", q_o[0], 4'd15);
        step(0, 1, 0, 4'd0, 0);
        chk("wrap_14", q_o[0], 4'd14);
        chk("wrap_borrow_cnt", 4'(bcnt[0]), 4'd1);

        // One-shot: 3,2,1,0 then DONE held for five more edges.
        bcnt[0] = 0;
        step(0, 0, 1, 4'd3, 1);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 4'd0, 1);
        chk("oneshot_zero", q_o[0], 4'd0);
        chk("oneshot_not_done_yet", 4'(done_o[0]), 4'd0);
        for (int i = 0; i < 6; i++)
            step(0, 1, 0, 4'd0, 1);
        chk("oneshot_done", 4'(done_o[0]), 4'd1);
        chk("oneshot_hold", q_o[0], 4'd0);
        chk("oneshot_no_borrow", 4'(bcnt[0]), 4'd0);
        step(0, 0, 1, 4'd1, 1);
        chk("reload_done", 4'(done_o[0]), 4'd0);
        chk("reload_q", q_o[0], 4'd1);

        // Modulus 10: saturation on load and wrap to 9.
        step(0, 0, 1, 4'd12, 0);
        chk("sat_m10", q_o[1], 4'd9);
        chk("nosat_m16", q_o[0], 4'd12);
        bcnt[1] = 0;
        step(0, 0, 1, 4'd0, 0);
        step(0, 1, 0, 4'd0, 0);
        chk("m10_wrap", q_o[1], 4'd9);
        for (int i = 0; i < 19; i++)
            step(0, 1, 0, 4'd0, 0);
        chk("m10_borrow_cnt", 4'(bcnt[1]), 4'd2);

        // Hold with T=0, then load beats count.
        step(0, 0, 1, 4'd5, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 4'd0, 0);
        chk("hold_q", q_o[0], 4'd5);
        step(0, 1, 1, 4'd7, 0);
        chk("load_over_count", q_o[0], 4'd7);

        // Clear mid one-shot returns to IDLE, not DONE.
        step(0, 0, 1, 4'd3, 1);
        step(0, 1, 0, 4'd0, 1);
        chk("mid_q2", q_o[0], 4'd2);
        step(1, 1, 0, 4'd0, 1);
        chk("mid_clear_q", q_o[0], 4'd0);
        chk("mid_clear_done", 4'(done_o[0]), 4'd0);
        step(0, 1, 0, 4'd0, 0);
        chk("idle_borrow", 4'(last_b[0]), 4'd1);
        chk("idle_wrap", q_o[0], 4'd15);

        // Randomized phase against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
